// File: rtl/ir_sched_pkg.sv
// ir_sched_pkg: command bit positions, stop command and scheduler state shared by the
// IR packet scheduler and its period timer.
package ir_sched_pkg;
   localparam int CMD_RIGHT   = 0;
   localparam int CMD_LEFT    = 1;
   localparam int CMD_BACK    = 2;
   localparam int CMD_FORWARD = 3;
   localparam logic [3:0] CMD_STOP = 4'b0000;
   localparam int TIMER_W = 24;
   typedef enum logic [1:0] {IDLE, COUNT, FIRE} sched_state_t;
endpackage

// File: rtl/ir_period_timer.sv
// ir_period_timer: period counter 0..PERIOD_CYCLES-1 that wraps on terminal count and
// is held at zero while clear is high.
module ir_period_timer
   import ir_sched_pkg::*;
#(
   parameter int PERIOD_CYCLES = 10000000
)(
   input  logic CLK,
   input  logic RESETN,
   input  logic clear,
   output logic terminal
);
   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(PERIOD_CYCLES - 1);
   logic [TIMER_W-1:0] count;
   assign terminal = count == LAST;
   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) count <= '0;
      else count <= (clear || terminal) ? '0 : count + 1'b1;
endmodule

// File: rtl/ir_packet_scheduler.sv
// ir_packet_scheduler: periodic IR packet launcher arbitrating bus and switch commands.
// Define IRSCHED_IMMEDIATE_EN to make an accepted bus write launch a packet right away.
module ir_packet_scheduler
   import ir_sched_pkg::*;
#(
   parameter int PERIOD_CYCLES    = 10000000,
   parameter int BUS_HOLD_PACKETS = 5
)(
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       ENABLE,
   input  logic       SW_VALID,
   input  logic [3:0] SW_COMMAND,
   input  logic       BUS_REQ,
   input  logic [3:0] BUS_COMMAND,
   output logic       BUS_ACK,
   output logic       SEND_PACKET,
   output logic [3:0] COMMAND,
   output logic       SRC_SEL
);
   localparam logic [3:0] HOLD_LOAD = 4'(BUS_HOLD_PACKETS);
   sched_state_t state;
   logic [3:0] pending;
   logic [3:0] hold;
   logic terminal;
   logic force_fire;
   logic fire_now;
   assign fire_now = state == FIRE && ENABLE;
`ifdef IRSCHED_IMMEDIATE_EN
   // Request waits one extra cycle when the FSM is already in FIRE, keeping pulses apart.
   logic imm_req;
   assign force_fire = imm_req && state == COUNT;
   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) imm_req <= 1'b0;
      else imm_req <= ENABLE && (BUS_REQ || (imm_req && !force_fire));
`else
   assign force_fire = 1'b0;
`endif
   ir_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .clear   (!ENABLE || state != COUNT || force_fire),
      .terminal(terminal)
   );
   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         state       <= IDLE;
         pending     <= CMD_STOP;
         hold        <= '0;
         BUS_ACK     <= 1'b0;
         SEND_PACKET <= 1'b0;
         COMMAND     <= CMD_STOP;
         SRC_SEL     <= 1'b0;
      end else begin
         BUS_ACK     <= BUS_REQ;
         SEND_PACKET <= fire_now;
         state       <= !ENABLE ? IDLE : (state == COUNT && (terminal || force_fire)) ? FIRE : COUNT;
         if (fire_now) begin
            COMMAND <= |hold ? pending : SW_VALID ? SW_COMMAND : CMD_STOP;
            SRC_SEL <= |hold;
         end
         // A bus write on the FIRE cycle reloads after that packet used the old hold.
         if (BUS_REQ) begin
            pending <= BUS_COMMAND;
            hold    <= HOLD_LOAD;
         end else if (fire_now && |hold) hold <= hold - 1'b1;
      end
endmodule

// File: tb/tb_ir_packet_scheduler.sv
// tb_ir_packet_scheduler: randomized scoreboard bench with a timestamp-based reference
// model of packet launches, bus acknowledges and command arbitration.
module tb_ir_packet_scheduler;
   localparam int P = 100;
   localparam int H = 3;
   logic CLK = 1'b0, RESETN = 1'b0, ENABLE = 1'b0, SW_VALID = 1'b0, BUS_REQ = 1'b0;
   logic [3:0] SW_COMMAND = 4'd0, BUS_COMMAND = 4'd0;
   logic BUS_ACK, SEND_PACKET, SRC_SEL;
   logic [3:0] COMMAND;
   int checks = 0, errors = 0;
   typedef struct {longint t; logic [3:0] cmd; logic src;} pkt_t;
   pkt_t pkt_q[$];
   longint ack_q[$];
   longint cyc = 0, pkt_cyc = -1, imm_cyc = -1;
   bit running = 0;
   int hold = 0;
   logic [3:0] pending = 4'd0, cur_cmd = 4'd0;
   logic cur_src = 1'b0;

   always #5 CLK = ~CLK;

   ir_packet_scheduler #(.PERIOD_CYCLES(P), .BUS_HOLD_PACKETS(H)) dut (
      .CLK(CLK), .RESETN(RESETN), .ENABLE(ENABLE), .SW_VALID(SW_VALID),
      .SW_COMMAND(SW_COMMAND), .BUS_REQ(BUS_REQ), .BUS_COMMAND(BUS_COMMAND),
      .BUS_ACK(BUS_ACK), .SEND_PACKET(SEND_PACKET), .COMMAND(COMMAND), .SRC_SEL(SRC_SEL)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: each launch is due P+1 edges after the previous one (or after enable).
   initial forever begin
      @(posedge CLK);
      cyc++;
      if (!RESETN) begin
         running = 0; hold = 0; pending = 4'd0; cur_cmd = 4'd0; cur_src = 1'b0;
         pkt_cyc = -1; imm_cyc = -1;
      end else begin
         if (!ENABLE) begin
            running = 0; imm_cyc = -1;
         end else if (!running) begin
            running = 1; pkt_cyc = cyc + P + 1;
         end else if (cyc == pkt_cyc || cyc == imm_cyc) begin
            if (hold > 0) begin
               cur_cmd = pending; cur_src = 1'b1; hold--;
            end else begin
               cur_cmd = SW_VALID ? SW_COMMAND : 4'd0; cur_src = 1'b0;
            end
            pkt_q.push_back('{t: $time, cmd: cur_cmd, src: cur_src});
            pkt_cyc = cyc + P + 1;
            if (cyc == imm_cyc) imm_cyc = -1;
         end
         if (BUS_REQ) begin
            pending = BUS_COMMAND; hold = H;
            ack_q.push_back($time);
`ifdef IRSCHED_IMMEDIATE_EN
            if (ENABLE) imm_cyc = (pkt_cyc == cyc + 1) ? cyc + 3 : cyc + 2;
`endif
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a pulse.
   initial begin
      longint e;
      pkt_t p;
      int tick = 0;
      forever begin
         @(negedge CLK);
         if (RESETN) begin
            e = $time - 5;
            while (pkt_q.size() > 0 && pkt_q[0].t < e) begin
               p = pkt_q.pop_front();
               chk("pkt_missing_time", 64'(e), 64'(p.t));
            end
            while (ack_q.size() > 0 && ack_q[0] < e) chk("ack_missing_time", 64'(e), 64'(ack_q.pop_front()));
            if (SEND_PACKET) begin
               if (pkt_q.size() == 0) chk("pkt_unexpected", 64'(SEND_PACKET), 64'(0));
               else begin
                  p = pkt_q.pop_front();
                  chk("pkt_time", 64'(e), 64'(p.t));
                  chk("pkt_command", 64'(COMMAND), 64'(p.cmd));
                  chk("pkt_src_sel", 64'(SRC_SEL), 64'(p.src));
               end
            end
            if (BUS_ACK) begin
               if (ack_q.size() == 0) chk("ack_unexpected", 64'(BUS_ACK), 64'(0));
               else chk("ack_time", 64'(e), 64'(ack_q.pop_front()));
            end
            tick++;
            if (!SEND_PACKET && tick % 8 == 0) begin
               chk("command_hold", 64'(COMMAND), 64'(cur_cmd));
               chk("src_sel_hold", 64'(SRC_SEL), 64'(cur_src));
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic bus(input logic [3:0] c);
      BUS_REQ = 1'b1; BUS_COMMAND = c;
      @(negedge CLK);
      BUS_REQ = 1'b0;
   endtask

   task automatic wait_edge(input longint target);
      for (int i = 0; i < 400 && cyc + 1 != target; i++) @(negedge CLK);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_send"}, 64'(SEND_PACKET), 64'(0));
      chk({tag, "_ack"}, 64'(BUS_ACK), 64'(0));
      chk({tag, "_command"}, 64'(COMMAND), 64'(0));
      chk({tag, "_src_sel"}, 64'(SRC_SEL), 64'(0));
   endtask

   initial begin
      int gap = 0;
      cycles(3);
      check_zero("reset");
      RESETN = 1'b1;
      ENABLE = 1'b1; SW_VALID = 1'b1; SW_COMMAND = 4'b1000;
      cycles(330);
      bus(4'b0101);
      cycles(520);
      SW_VALID = 1'b0;
      cycles(220);
      wait_edge(pkt_cyc - 1);
      bus(4'b0011);
      cycles(250);
      SW_VALID = 1'b1; SW_COMMAND = 4'b0100;
      wait_edge(pkt_cyc - 50);
      ENABLE = 1'b0;
      cycles(77);
      ENABLE = 1'b1;
      cycles(230);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) ENABLE = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 19) == 0) begin
            SW_VALID = 1'($urandom); SW_COMMAND = 4'($urandom);
         end
         if (gap >= 4 && $urandom_range(0, 59) == 0) begin
            BUS_REQ = 1'b1; BUS_COMMAND = 4'($urandom); gap = 0;
         end else begin
            BUS_REQ = 1'b0; gap++;
         end
         @(negedge CLK);
      end
      BUS_REQ = 1'b0; ENABLE = 1'b1;
      cycles(40);
      #1 RESETN = 1'b0;
      #1 check_zero("async_reset");
      cycles(2);
      #1 RESETN = 1'b1;
      cycles(60);
      bus(4'b0110);
      cycles(260);
      cycles(10);
      chk("pkt_queue_drained", 64'(pkt_q.size()), 64'(0));
      chk("ack_queue_drained", 64'(ack_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
